instruction_queue: RTL and testbench

Instruction queue between the fetch stage and decode. Each cycle it accepts one PC/instruction pair from fetch plus instruction memory and buffers up to DEPTH entries in order. It presents the oldest entry to decode through a valid/ready handshake and drives a stall back to fetch when full. A flush from branch resolution, asserted in the same cycle that fetch's next_PC_select is taken, discards all wrong-path entries.

---
 rtl/instruction_queue.sv | 96 +++++++++
 tb/tb_instruction_queue.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/instruction_queue.sv
// In-order buffer between fetch and decode: circular store of {PC, instruction}
// with first-word-fall-through head, fetch stall when full, flush on redirect.
module instruction_queue #(
  parameter int ADDRESS_BITS = 16,
  parameter int DATA_WIDTH   = 32,
  parameter int DEPTH        = 4
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     in_valid,
  input  logic [ADDRESS_BITS-1:0]  in_PC,
  input  logic [DATA_WIDTH-1:0]    in_instruction,
  output logic                     in_ready,
  output logic                     fetch_stall,
  input  logic                     flush,
  output logic                     out_valid,
  output logic [ADDRESS_BITS-1:0]  out_PC,
  output logic [DATA_WIDTH-1:0]    out_instruction,
  input  logic                     out_ready,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(DEPTH);

  typedef enum logic [1:0] {
    EMPTY,
    PARTIAL,
    FULL
  } occ_e;

  logic [PTR_W-1:0]        wr_ptr;
  logic [PTR_W-1:0]        rd_ptr;
  logic [ADDRESS_BITS-1:0] pc_mem    [DEPTH];
  logic [DATA_WIDTH-1:0]   instr_mem [DEPTH];
  occ_e                    occ;
  logic                    push;
  logic                    pop;

  // Occupancy state is purely a decode of count, so handshake outputs never
  // depend combinationally on in_valid, out_ready or flush.
  always_comb begin
    occ = PARTIAL;
    if (count == '0)
      occ = EMPTY;
    else if (count == FULL_COUNT)
      occ = FULL;
  end

  assign in_ready        = (occ != FULL);
  assign fetch_stall     = !in_ready;
  assign out_valid       = (occ != EMPTY);
  assign out_PC          = pc_mem[rd_ptr];
  assign out_instruction = instr_mem[rd_ptr];

  assign push = in_valid && in_ready && !flush;
  assign pop  = out_valid && out_ready && !flush;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        pc_mem[i]    <= '0;
        instr_mem[i] <= '0;
      end
    end else begin
      if (in_valid && !in_ready && !flush)
        overflow <= 1'b1;

      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        count  <= '0;
      end else begin
        if (push) begin
          pc_mem[wr_ptr]    <= in_PC;
          instr_mem[wr_ptr] <= in_instruction;
          wr_ptr            <= wr_ptr + 1'b1;
        end
        if (pop)
          rd_ptr <= rd_ptr + 1'b1;
        case ({push, pop})
          2'b10:   count <= count + 1'b1;
          2'b01:   count <= count - 1'b1;
          default: count <= count;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_instruction_queue.sv
// Directed bench for instruction_queue: fill/drain, overflow, wrap,
// streaming, flush and asynchronous reset, with hand-computed expectations.
module tb_instruction_queue;

  logic        clock;
  logic        reset;
  logic        in_valid;
  logic [15:0] in_PC;
  logic [31:0] in_instruction;
  logic        in_ready;
  logic        fetch_stall;
  logic        flush;
  logic        out_valid;
  logic [15:0] out_PC;
  logic [31:0] out_instruction;
  logic        out_ready;
  logic [2:0]  count;
  logic        overflow;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  instruction_queue #(
    .ADDRESS_BITS(16),
    .DATA_WIDTH  (32),
    .DEPTH       (4)
  ) dut (
    .clock          (clock),
    .reset          (reset),
    .in_valid       (in_valid),
    .in_PC          (in_PC),
    .in_instruction (in_instruction),
    .in_ready       (in_ready),
    .fetch_stall    (fetch_stall),
    .flush          (flush),
    .out_valid      (out_valid),
    .out_PC         (out_PC),
    .out_instruction(out_instruction),
    .out_ready      (out_ready),
    .count          (count),
    .overflow       (overflow)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp)
      n_pass++;
    else
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  // Advance one rising edge and settle 1 time unit after it.
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  function automatic logic [31:0] instr_of(input logic [15:0] pc);
    return 32'hC0DE_0000 | {16'h0, pc};
  endfunction

  initial begin
    reset = 1'b1;
    in_valid = 1'b0;
    in_PC = '0;
    in_instruction = '0;
    flush = 1'b0;
    out_ready = 1'b0;

    #2;
    check("rst_count", count, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_fetch_stall", fetch_stall, 0);
    check("rst_overflow", overflow, 0);
    check("rst_out_PC", out_PC, 0);
    check("rst_out_instr", out_instruction, 0);
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;

    // Two pushes, then drain.
    in_valid = 1'b1; in_PC = 16'h0000; in_instruction = 32'h0000_AAAA;
    step();
    check("t1_valid_after_first", out_valid, 1);
    in_PC = 16'h0001; in_instruction = 32'h0000_BBBB;
    step();
    in_valid = 1'b0;
    check("t1_count2", count, 2);
    check("t1_head_pc", out_PC, 16'h0000);
    check("t1_head_instr", out_instruction, 32'h0000_AAAA);
    out_ready = 1'b1;
    step();
    check("t1_pop1_pc", out_PC, 16'h0001);
    check("t1_pop1_instr", out_instruction, 32'h0000_BBBB);
    check("t1_pop1_count", count, 1);
    step();
    check("t1_empty_valid", out_valid, 0);
    check("t1_empty_count", count, 0);
    out_ready = 1'b0;

    // Fill to full, then attempt an overflowing push.
    in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_PC = 16'h0010 + 16'(i);
      in_instruction = instr_of(in_PC);
      step();
    end
    check("t2_full_count", count, 4);
    check("t2_full_in_ready", in_ready, 0);
    check("t2_full_stall", fetch_stall, 1);
    check("t2_no_overflow_yet", overflow, 0);
    in_PC = 16'h0014; in_instruction = instr_of(16'h0014);
    step();
    in_valid = 1'b0;
    check("t2_overflow", overflow, 1);
    check("t2_head_kept", out_PC, 16'h0010);
    check("t2_count_kept", count, 4);

    // Pop one from full, push 0014 next cycle, then drain across the wrap.
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check("t3_count3", count, 3);
    check("t3_in_ready", in_ready, 1);
    in_valid = 1'b1; in_PC = 16'h0014; in_instruction = instr_of(16'h0014);
    step();
    in_valid = 1'b0;
    check("t3_count4", count, 4);
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check($sformatf("t3_drain_pc%0d", i), out_PC, 16'h0011 + 16'(i));
      check($sformatf("t3_drain_instr%0d", i), out_instruction, instr_of(16'h0011 + 16'(i)));
      step();
    end
    check("t3_drained", out_valid, 0);
    out_ready = 1'b0;

    // Streaming at count=2: simultaneous push and pop.
    in_valid = 1'b1;
    for (int i = 0; i < 2; i++) begin
      in_PC = 16'h0020 + 16'(i);
      in_instruction = instr_of(in_PC);
      step();
    end
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      check($sformatf("t4_head%0d", i), out_PC, 16'h0020 + 16'(i));
      check($sformatf("t4_count%0d", i), count, 2);
      in_PC = 16'h0022 + 16'(i);
      in_instruction = instr_of(in_PC);
      step();
    end
    check("t4_final_head", out_PC, 16'h0028);
    check("t4_final_count", count, 2);

    // Flush at count=3 with a concurrent push and pop.
    out_ready = 1'b0;
    in_PC = 16'h002A; in_instruction = instr_of(16'h002A);
    step();
    check("t5_count3", count, 3);
    flush = 1'b1; out_ready = 1'b1;
    in_PC = 16'h1111; in_instruction = instr_of(16'h1111);
    step();
    flush = 1'b0; out_ready = 1'b0;
    check("t5_flush_count", count, 0);
    check("t5_flush_valid", out_valid, 0);
    check("t5_flush_in_ready", in_ready, 1);
    check("t5_overflow_kept", overflow, 1);
    step();
    check("t5_repush_valid", out_valid, 1);
    check("t5_repush_pc", out_PC, 16'h1111);
    check("t5_repush_count", count, 1);

    // Asynchronous reset between edges.
    in_PC = 16'h1112; in_instruction = instr_of(16'h1112);
    step();
    in_valid = 1'b0;
    check("t6_pre_count", count, 2);
    check("t6_pre_overflow", overflow, 1);
    #1 reset = 1'b1;
    #1;
    check("t6_async_count", count, 0);
    check("t6_async_valid", out_valid, 0);
    check("t6_async_pc", out_PC, 16'h0000);
    check("t6_async_instr", out_instruction, 32'h0);
    check("t6_async_overflow", overflow, 0);
    step();
    reset = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
